// File: rtl/delta_seq_ctrl_if.sv
// Control bundle between the back-prop top-level FSM (master) and the delta sequencer (slave).
// The master issues start/n_steps; the sequencer returns status, timestep index and datapath selects.
interface delta_seq_if #(
  parameter int TW = 8
);
  logic          start;
  logic [TW-1:0] n_steps;
  logic          busy;
  logic          done;
  logic [TW-1:0] t_idx;
  logic [1:0]    sel_in1;
  logic [1:0]    sel_in2;
  logic          sel_in3;
  logic [1:0]    sel_in4;
  logic [2:0]    sel_in5;
  logic [1:0]    sel_x1_1;
  logic          sel_x1_2;
  logic [1:0]    sel_x2_2;
  logic          sel_as_1;
  logic [1:0]    sel_as_2;
  logic          sel_addsub;
  logic [1:0]    sel_temp;
  logic          dgate_valid;
  logic [1:0]    gate_id;
  logic          dstate_valid;

  modport master (
    output start, n_steps,
    input  busy, done, t_idx, sel_in1, sel_in2, sel_in3, sel_in4, sel_in5,
           sel_x1_1, sel_x1_2, sel_x2_2, sel_as_1, sel_as_2, sel_addsub, sel_temp,
           dgate_valid, gate_id, dstate_valid
  );

  modport slave (
    input  start, n_steps,
    output busy, done, t_idx, sel_in1, sel_in2, sel_in3, sel_in4, sel_in5,
           sel_x1_1, sel_x1_2, sel_x2_2, sel_as_1, sel_as_2, sel_addsub, sel_temp,
           dgate_valid, gate_id, dstate_valid
  );
endinterface

// File: rtl/delta_seq_ctrl.sv
// LSTM back-prop delta sequencer: replays a 12-step micro-op schedule per timestep, walking t_idx down to 0.
// Latency: start in c -> step0 in c+1 -> done in c+1+12*n_steps; start is ignored outside IDLE.
module delta_seq_ctrl #(
  parameter int TW    = 8,
  parameter int NSTEP = 12
) (
  input  logic       clk,
  input  logic       rst,
  delta_seq_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [1:0] in1;
    logic [1:0] in2;
    logic       in3;
    logic [1:0] in4;
    logic [2:0] in5;
    logic [1:0] x11;
    logic       x12;
    logic [1:0] x22;
    logic       as1;
    logic [1:0] as2;
    logic       addsub;
    logic [1:0] temp;
    logic       dgv;
    logic [1:0] gid;
    logic       dsv;
  } sel_t;

  state_t        state, state_nxt;
  logic [3:0]    step, step_nxt;
  logic [TW-1:0] t_q, t_nxt;
  logic          first, first_nxt;
  logic          busy_q, done_q, done_nxt;
  sel_t          sel_q, sel_nxt;

  // Schedule row for a step; the first timestep seeds from h/t instead of the carried d_out.
  function automatic sel_t decode(input logic [3:0] s, input logic f);
    sel_t d;
    d = '0;
    case (s)
      4'd0:  begin d.in2 = 2'd2; d.in4 = f ? 2'd1 : 2'd0; d.in5 = f ? 3'd0 : 3'd1; end
      4'd1:  d.addsub = f;
      4'd2:  begin d.in4 = 2'd2; d.in5 = 3'd1; d.addsub = 1'b1; end
      4'd3:  begin d.as2 = 2'd3; d.addsub = 1'b1; d.temp = 2'd2; end
      4'd4:  begin
        d.in1 = 2'd2; d.in5 = 3'd4; d.x11 = 2'd1; d.x12 = 1'b1;
        d.as1 = 1'b1; d.as2 = 2'd2; d.temp = 2'd1;
      end
      4'd5:  begin
        d.in1 = 2'd1; d.in2 = 2'd1; d.in3 = 1'b1; d.as2 = 2'd1; d.temp = 2'd1; d.dsv = 1'b1;
      end
      4'd6:  begin
        d.in1 = 2'd1; d.in3 = 1'b1; d.in4 = 2'd2; d.in5 = 3'd2;
        d.x11 = 2'd2; d.addsub = 1'b1; d.temp = 2'd2;
      end
      4'd7:  begin d.in3 = 1'b1; d.x22 = 2'd1; d.temp = 2'd2; d.dgv = 1'b1; d.gid = 2'd0; end
      4'd8:  begin
        d.in1 = 2'd3; d.in2 = 2'd3; d.in4 = 2'd2; d.in5 = 3'd3;
        d.x11 = 2'd2; d.x22 = 2'd2; d.addsub = 1'b1; d.temp = 2'd2;
      end
      4'd9:  begin
        d.in3 = 1'b1; d.x11 = 2'd2; d.x12 = 1'b1; d.x22 = 2'd1; d.as1 = 1'b1;
        d.temp = 2'd2; d.dgv = 1'b1; d.gid = 2'd1;
      end
      4'd10: begin
        d.in2 = 2'd1; d.in4 = 2'd2; d.in5 = 3'd4; d.x11 = 2'd2; d.x22 = 2'd2;
        d.addsub = 1'b1; d.temp = 2'd2; d.dgv = 1'b1; d.gid = 2'd2;
      end
      4'd11: begin d.x22 = 2'd2; d.temp = 2'd2; d.dgv = 1'b1; d.gid = 2'd3; end
      default: d = '0;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= 4'd0;
      t_q    <= '0;
      first  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      t_q    <= t_nxt;
      first  <= first_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= done_nxt;
      sel_q  <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    t_nxt     = t_q;
    first_nxt = first;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.n_steps != '0) begin
            state_nxt = RUN;
            step_nxt  = 4'd0;
            t_nxt     = bus.n_steps - TW'(1);
            first_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (step == LAST) begin
          step_nxt = 4'd0;
          if (t_q == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            t_nxt     = t_q - TW'(1);
            first_nxt = 1'b0;
          end
        end else begin
          step_nxt = step + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Selects are registered from the next step so step k's row is live during RUN cycle k.
    sel_nxt = (state_nxt == RUN) ? decode(step_nxt, first_nxt) : '0;
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.t_idx        = t_q;
  assign bus.sel_in1      = sel_q.in1;
  assign bus.sel_in2      = sel_q.in2;
  assign bus.sel_in3      = sel_q.in3;
  assign bus.sel_in4      = sel_q.in4;
  assign bus.sel_in5      = sel_q.in5;
  assign bus.sel_x1_1     = sel_q.x11;
  assign bus.sel_x1_2     = sel_q.x12;
  assign bus.sel_x2_2     = sel_q.x22;
  assign bus.sel_as_1     = sel_q.as1;
  assign bus.sel_as_2     = sel_q.as2;
  assign bus.sel_addsub   = sel_q.addsub;
  assign bus.sel_temp     = sel_q.temp;
  assign bus.dgate_valid  = sel_q.dgv;
  assign bus.gate_id      = sel_q.gid;
  assign bus.dstate_valid = sel_q.dsv;
endmodule

// File: tb/tb_delta_seq_ctrl.sv
// Directed bench for delta_seq_ctrl: schedule table keyed by (first pass, step), plus hand-written
// sequences for n_steps=0, start during RUN/DONE, and mid-run reset.
module tb_delta_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delta_seq_if #(.TW(8)) bus ();
  delta_seq_ctrl #(.TW(8), .NSTEP(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit    first;
    int    step;
    string sel;   // digits: in1 in2 in3 in4 in5 x11 x12 x22 as1 as2 addsub temp dgv gid dsv
  } vec_t;

  vec_t tbl[14];
  int n_chk = 0;
  int n_err = 0;
  int dg_cnt, ds_cnt;

  wire [24:0] dut_sel = {bus.sel_in1, bus.sel_in2, bus.sel_in3, bus.sel_in4, bus.sel_in5,
                         bus.sel_x1_1, bus.sel_x1_2, bus.sel_x2_2, bus.sel_as_1, bus.sel_as_2,
                         bus.sel_addsub, bus.sel_temp, bus.dgate_valid, bus.gate_id,
                         bus.dstate_valid};

  function automatic logic [24:0] parse(input string s);
    logic [24:0] r;
    int w[15] = '{2, 2, 1, 2, 3, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
    r = '0;
    for (int i = 0; i < 15; i++) r = (r << w[i]) | 25'(s.getc(i) - 8'd48);
    return r;
  endfunction

  // Later passes differ only where a row exists for first=0; otherwise the first-pass row applies.
  function automatic logic [24:0] lookup(input bit first, input int step);
    for (int i = 0; i < 14; i++)
      if (tbl[i].first == first && tbl[i].step == step) return parse(tbl[i].sel);
    for (int i = 0; i < 14; i++)
      if (tbl[i].first && tbl[i].step == step) return parse(tbl[i].sel);
    return '1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " t_idx"}, 32'(bus.t_idx), 32'd0);
    chk({tag, " sel"}, 32'(dut_sel), 32'd0);
  endtask

  // Pulse start for one cycle; afterwards n_steps is scrambled to show it is not re-sampled.
  task automatic do_start(input int n);
    bus.start   = 1'b1;
    bus.n_steps = 8'(n);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.n_steps = 8'hAA;
  endtask

  // Entered at the negedge of step 0; leaves at the negedge of the done cycle (or after a reset).
  task automatic run_seq(input int n, input int inj_p, input int inj_s,
                         input int ab_p, input int ab_s);
    dg_cnt = 0;
    ds_cnt = 0;
    for (int p = 0; p < n; p++) begin
      for (int s = 0; s < 12; s++) begin
        bus.start = 1'b0;
        chk($sformatf("busy p%0d s%0d", p, s), 32'(bus.busy), 32'd1);
        chk($sformatf("done p%0d s%0d", p, s), 32'(bus.done), 32'd0);
        chk($sformatf("t_idx p%0d s%0d", p, s), 32'(bus.t_idx), 32'(n - 1 - p));
        chk($sformatf("sel p%0d s%0d", p, s), 32'(dut_sel), 32'(lookup(p == 0, s)));
        dg_cnt += int'(bus.dgate_valid);
        ds_cnt += int'(bus.dstate_valid);
        if (p == inj_p && s == inj_s) begin
          bus.start   = 1'b1;
          bus.n_steps = 8'd9;
        end
        if (p == ab_p && s == ab_s) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    chk("end done", 32'(bus.done), 32'd1);
    chk("end busy", 32'(bus.busy), 32'd0);
    chk("end sel", 32'(dut_sel), 32'd0);
    chk("end t_idx", 32'(bus.t_idx), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 0,  "020100000000000"};
    tbl[1]  = '{1'b1, 1,  "000000000010000"};
    tbl[2]  = '{1'b1, 2,  "000210000010000"};
    tbl[3]  = '{1'b1, 3,  "000000000312000"};
    tbl[4]  = '{1'b1, 4,  "200041101201000"};
    tbl[5]  = '{1'b1, 5,  "111000000101001"};
    tbl[6]  = '{1'b1, 6,  "101222000012000"};
    tbl[7]  = '{1'b1, 7,  "001000010002100"};
    tbl[8]  = '{1'b1, 8,  "330232020012000"};
    tbl[9]  = '{1'b1, 9,  "001002111002110"};
    tbl[10] = '{1'b1, 10, "010242020012120"};
    tbl[11] = '{1'b1, 11, "000000020002130"};
    tbl[12] = '{1'b0, 0,  "020010000000000"};
    tbl[13] = '{1'b0, 1,  "000000000000000"};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.n_steps = 8'd0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single timestep: done at c+13, four gate deltas and one state delta.
    do_start(1);
    run_seq(1, -1, -1, -1, -1);
    chk("n1 dgate count", 32'(dg_cnt), 32'd4);
    chk("n1 dstate count", 32'(ds_cnt), 32'd1);
    @(negedge clk);
    chk_idle("after n1");

    // Three timesteps: t_idx 2,1,0 and first-pass-only seeding on s0/s1.
    do_start(3);
    run_seq(3, -1, -1, -1, -1);
    chk("n3 dgate count", 32'(dg_cnt), 32'd12);
    chk("n3 dstate count", 32'(ds_cnt), 32'd3);
    @(negedge clk);
    chk_idle("after n3");

    // Zero timesteps: immediate done, never busy.
    do_start(0);
    chk("n0 done", 32'(bus.done), 32'd1);
    chk("n0 busy", 32'(bus.busy), 32'd0);
    chk("n0 sel", 32'(dut_sel), 32'd0);
    @(negedge clk);
    chk_idle("after n0");

    // Start pulse at step 5 with n_steps=9 must not extend a 2-step run.
    do_start(2);
    run_seq(2, 0, 5, -1, -1);
    @(negedge clk);
    chk_idle("after restart attempt");

    // Reset at step 7 of pass 2, then a fresh single-step run.
    do_start(3);
    run_seq(3, -1, -1, 1, 7);
    chk_idle("mid-run reset");
    @(negedge clk);
    chk_idle("reset settle");
    do_start(1);
    run_seq(1, -1, -1, -1, -1);
    chk("post-reset dgate count", 32'(dg_cnt), 32'd4);

    // Back-to-back: start in the DONE cycle is dropped, start in the next IDLE cycle is taken.
    do_start(1);
    chk("start in DONE ignored busy", 32'(bus.busy), 32'd0);
    chk("start in DONE ignored done", 32'(bus.done), 32'd0);
    do_start(1);
    run_seq(1, -1, -1, -1, -1);
    @(negedge clk);
    chk_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
